message_delivery_multi: RTL and testbench
=========================================

// Module: message_delivery_multi
// PURPOSE
// Delivers a multi-word channel message to a target process. If the target is
// running on any of NUM_CORES cores, it flags that core (one-hot) and makes no
// memory access. Otherwise it pushes 1..MSG_WORDS_MAX words onto the target's
// data stack in memory and can rewrite its saved PC. Sits between the channel
// controller and the process-memory port. The parent windows that port to the
// target's process region.
// PARAMETERS
// ADDR_BITS      8   process id / memory address width
// DATA_BITS      16  memory word width; must be >= 2*ADDR_BITS and >= PC_BITS
// NUM_CORES      2   number of cores checked for direct delivery
// MSG_WORDS_MAX  4   maximum message length in words
// PC_BITS        9   width of the program-counter field in the PC word
// PORTS
// clk             in   1                      clock
// reset           in   1                      sync, active-high
// start           in   1                      request pulse; sampled only in IDLE
// busy            out  1                      high from start acceptance until done
// done            out  1                      one-cycle completion pulse
// error           out  1                      valid with done: stack collision, no writes made
// deliver_to_core out  NUM_CORES              one-hot direct-delivery flag, valid with done
// mem_rw          out  1                      `RAM_READ / `RAM_WRITE
// mem_addr        out  ADDR_BITS              word address in the target region
// mem_din         out  DATA_BITS              write data
// mem_dout        in   DATA_BITS              read data
// core_process    in   NUM_CORES*ADDR_BITS    process id per core; core i at [i*ADDR_BITS +: ADDR_BITS]
// target_process  in   ADDR_BITS              destination process id
// msg_data        in   MSG_WORDS_MAX*DATA_BITS  word k at [k*DATA_BITS +: DATA_BITS]
// msg_count       in   $clog2(MSG_WORDS_MAX+1)  words to push (0..MSG_WORDS_MAX)
// needs_jump      in   1                      rewrite saved PC after the push
// jump_dest       in   PC_BITS                new PC value
// BEHAVIOUR
// - Reset: state IDLE; busy, done, error, deliver_to_core = 0; mem_rw = READ.
//   Reset mid-operation aborts at the same edge. No further writes are issued.
// - start in IDLE at edge E0 latches target, msg_data, msg_count, needs_jump and
//   jump_dest. busy rises at E0. start while busy is ignored.
// - MATCH (1 cycle): lowest-index core i with core_process[i] == target wins.
//   On a win, done and deliver_to_core[i] are high in the cycle after E1, then
//   IDLE. No memory access is made.
// - Each memory state lasts 2 cycles, with address, rw and din held for both.
//   mem_dout is sampled at the end of the 2nd cycle of a read state.
// - Word 0 (addr 0): data SP = [2*ADDR_BITS-1:ADDR_BITS], call SP = [ADDR_BITS-1:0].
// - Word 1 (addr 1): PC = [PC_BITS-1:0]; upper bits are flags and are preserved.
// - Sequence:
//   - RD_SP -> collision check.
//   - Collision when (SP - msg_count) <= callSP, computed in ADDR_BITS+1 bits
//     so that underflow counts as a collision. On collision: done + error, no writes.
//   - WR_SP writes {SP-msg_count, callSP}.
//   - WR_WORD k = 0..msg_count-1 writes msg word k at SP-1-k.
//   - If needs_jump: RD_PC, then WR_PC writes {flags, jump_dest}.
//   - Then done.
// - msg_count == 0 skips RD_SP, WR_SP and WR_WORD and goes to the PC phase or to done.
// - Latency: done is high in the cycle after edge E1 + 2*(2+msg_count) + (needs_jump ? 4 : 0).
//   For msg_count == 0 the stack term is 0.
// - Outside write states mem_rw = READ and mem_din is don't-care.
// - msg_count > MSG_WORDS_MAX is clamped to MSG_WORDS_MAX.
// STRUCTURE
// - messages.vh: state encodings; the SP/PC word field offsets; the 2-cycle access constant.
// - opcodes.vh: RAM_READ / RAM_WRITE.
// - Sub-module process_core_matcher (combinational priority match, NUM_CORES
//   parametrised): outputs hit and a one-hot grant.
// - Word counter: $clog2(MSG_WORDS_MAX+1) bits. Access ticker: 1 bit.
// TESTING
// 1. NUM_CORES=4; core_process = {7,5,5,3}; target=5 -> deliver_to_core=0b0010
//    (lowest index wins), done in the cycle after E1, no mem_rw=WRITE.
// 2. Not resident; word0=0x4010; msg_count=3, msgs {A,B,C}; needs_jump=0 ->
//    word0=0x3D10, [0x3F]=A, [0x3E]=B, [0x3D]=C; done in the cycle after E1+10.
// 3. Word1=0xFE05; needs_jump=1; jump_dest=0x123; msg_count=1 ->
//    word1=0xFF23 (flags 0x7F kept); done in the cycle after E1+10.
// 4. Word0=0x1210; msg_count=3 -> collision (0x0F <= 0x10): error=1, no writes.
//    Repeat with word0=0x0210 -> underflow: error=1.
// 5. msg_count=0, needs_jump=0, not resident -> done in the cycle after E1; no memory access.
// 6. reset asserted in the 2nd WR_WORD -> from the next cycle: IDLE, busy=0,
//    no write. A start pulse during busy changes nothing.

Source files
------------

// File: rtl/message_delivery_multi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : message_delivery_multi_pkg                                    |
// | Purpose  : Shared state encodings, memory opcodes and word-layout        |
// |            constants for the channel message delivery block.             |
// | Contents : state_t FSM encoding, RAM_READ/RAM_WRITE opcodes, fixed       |
// |            addresses of the SP and PC words, access-ticker terminal value|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package message_delivery_multi_pkg;

   // Controller states; every memory state spans two cycles.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MATCH   = 3'd1,
      S_RD_SP   = 3'd2,
      S_WR_SP   = 3'd3,
      S_WR_WORD = 3'd4,
      S_RD_PC   = 3'd5,
      S_WR_PC   = 3'd6
   } state_t;

   // Memory opcodes driven on mem_rw.
   localparam logic RAM_READ  = 1'b0;
   localparam logic RAM_WRITE = 1'b1;

   // Word addresses inside the target process region.
   localparam int SP_WORD_ADDR = 0;
   localparam int PC_WORD_ADDR = 1;

   // Ticker value marking the second (final) cycle of a memory state.
   localparam logic ACCESS_LAST = 1'b1;

endpackage : message_delivery_multi_pkg
`default_nettype wire

// File: rtl/message_delivery_multi_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : message_delivery_multi_if                                     |
// | Purpose  : Process-memory port between the delivery block and the        |
// |            windowed process RAM.                                         |
// | Signals  : mem_rw   - RAM_READ / RAM_WRITE                               |
// |            mem_addr - word address inside the target region              |
// |            mem_din  - write data (to memory)                             |
// |            mem_dout - read data (from memory)                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface message_delivery_multi_if #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 16
);
   logic                 mem_rw;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [DATA_BITS-1:0] mem_din;
   logic [DATA_BITS-1:0] mem_dout;

   // Delivery block side: issues accesses.
   modport master (
      output mem_rw,
      output mem_addr,
      output mem_din,
      input  mem_dout
   );

   // Memory side: services accesses.
   modport slave (
      input  mem_rw,
      input  mem_addr,
      input  mem_din,
      output mem_dout
   );
endinterface : message_delivery_multi_if
`default_nettype wire

// File: rtl/message_delivery_multi_matcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : process_core_matcher                                          |
// | Purpose  : Combinational priority match of a target process id against   |
// |            the process running on each core. Lowest core index wins.     |
// | Ports    : core_process_i - packed per-core process ids                  |
// |            target_i       - process id to look for                       |
// |            hit_o          - at least one core runs the target            |
// |            grant_o        - one-hot winning core                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module process_core_matcher #(
   parameter int NUM_CORES = 2,
   parameter int ADDR_BITS = 8
) (
   input  logic [NUM_CORES*ADDR_BITS-1:0] core_process_i,
   input  logic [ADDR_BITS-1:0]           target_i,
   output logic                           hit_o,
   output logic [NUM_CORES-1:0]           grant_o
);

   logic [NUM_CORES-1:0] eq_w;

   for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_cmp
      assign eq_w[gi] = (core_process_i[gi*ADDR_BITS +: ADDR_BITS] == target_i);
   end

   // Isolate the lowest set bit of the equality vector.
   always_comb begin
      grant_o = '0;
      hit_o   = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (!hit_o && eq_w[i]) begin
            grant_o[i] = 1'b1;
            hit_o      = 1'b1;
         end
      end
   end

endmodule : process_core_matcher
`default_nettype wire

// File: rtl/message_delivery_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : message_delivery_multi                                        |
// | Purpose  : Delivers a multi-word channel message to a target process.    |
// |            Resident target -> one-hot core flag, no memory access.       |
// |            Otherwise -> push words on the target data stack and          |
// |            optionally rewrite its saved PC.                              |
// | Ports    : clk, reset (sync, active-high)                                |
// |            start / busy / done / error / deliver_to_core - control       |
// |            mem (master modport) - process-memory port                    |
// |            core_process, target_process, msg_data, msg_count,            |
// |            needs_jump, jump_dest - request payload                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module message_delivery_multi
   import message_delivery_multi_pkg::*;
#(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 16,
   parameter int NUM_CORES     = 2,
   parameter int MSG_WORDS_MAX = 4,
   parameter int PC_BITS       = 9
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  error,
   output logic [NUM_CORES-1:0]                  deliver_to_core,
   message_delivery_multi_if.master              mem,
   input  logic [NUM_CORES*ADDR_BITS-1:0]        core_process,
   input  logic [ADDR_BITS-1:0]                  target_process,
   input  logic [MSG_WORDS_MAX*DATA_BITS-1:0]    msg_data,
   input  logic [$clog2(MSG_WORDS_MAX+1)-1:0]    msg_count,
   input  logic                                  needs_jump,
   input  logic [PC_BITS-1:0]                    jump_dest
);

   localparam int CNT_BITS = $clog2(MSG_WORDS_MAX+1);
   localparam logic [CNT_BITS-1:0]  CNT_MAX = CNT_BITS'(MSG_WORDS_MAX);
   // Field offsets in the SP word: data SP above call SP.
   localparam int DATA_SP_LO = ADDR_BITS;
   localparam int CALL_SP_LO = 0;
   localparam logic [DATA_BITS-1:0] PC_MASK = {DATA_BITS{1'b1}} >> (DATA_BITS - PC_BITS);

   // Registered state and outputs
   state_t                           state_q;
   logic                             tick_q;
   logic [CNT_BITS-1:0]              word_q;
   logic [CNT_BITS-1:0]              count_q;
   logic [ADDR_BITS-1:0]             target_q;
   logic [MSG_WORDS_MAX*DATA_BITS-1:0] msg_q;
   logic                             jump_q;
   logic [PC_BITS-1:0]               dest_q;
   logic [ADDR_BITS-1:0]             sp_q;
   logic                             busy_q;
   logic                             done_q;
   logic                             error_q;
   logic [NUM_CORES-1:0]             deliver_q;
   logic                             rw_q;
   logic [ADDR_BITS-1:0]             addr_q;
   logic [DATA_BITS-1:0]             din_q;

   // Combinational helpers
   logic                             hit_d;
   logic [NUM_CORES-1:0]             grant_d;
   logic [CNT_BITS-1:0]              count_clamp_d;
   logic [ADDR_BITS-1:0]             rd_sp_d;
   logic [ADDR_BITS-1:0]             rd_call_sp_d;
   logic [ADDR_BITS:0]               sp_diff_d;
   logic                             collide_d;
   logic [DATA_BITS-1:0]             sp_word_d;
   logic [CNT_BITS-1:0]              word_d;
   logic [DATA_BITS-1:0]             msg_next_d;
   logic [DATA_BITS-1:0]             pc_word_d;

   process_core_matcher #(
      .NUM_CORES (NUM_CORES),
      .ADDR_BITS (ADDR_BITS)
   ) u_matcher (
      .core_process_i (core_process),
      .target_i       (target_q),
      .hit_o          (hit_d),
      .grant_o        (grant_d)
   );

   assign count_clamp_d = (msg_count > CNT_MAX) ? CNT_MAX : msg_count;

   assign rd_sp_d      = mem.mem_dout[DATA_SP_LO +: ADDR_BITS];
   assign rd_call_sp_d = mem.mem_dout[CALL_SP_LO +: ADDR_BITS];
   // One extra bit so that SP < msg_count shows up as a borrow.
   assign sp_diff_d    = {1'b0, rd_sp_d} - (ADDR_BITS+1)'(count_q);
   assign collide_d    = sp_diff_d[ADDR_BITS] || (sp_diff_d[ADDR_BITS-1:0] <= rd_call_sp_d);
   assign sp_word_d    = DATA_BITS'({sp_diff_d[ADDR_BITS-1:0], rd_call_sp_d});

   assign word_d       = word_q + CNT_BITS'(1);
   assign msg_next_d   = msg_q[int'(word_d)*DATA_BITS +: DATA_BITS];
   // Keep the flag bits above the PC field.
   assign pc_word_d    = (mem.mem_dout & ~PC_MASK) | DATA_BITS'(dest_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         tick_q    <= 1'b0;
         word_q    <= '0;
         count_q   <= '0;
         target_q  <= '0;
         msg_q     <= '0;
         jump_q    <= 1'b0;
         dest_q    <= '0;
         sp_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         deliver_q <= '0;
         rw_q      <= RAM_READ;
         addr_q    <= '0;
         din_q     <= '0;
      end else begin
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         deliver_q <= '0;

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  target_q <= target_process;
                  msg_q    <= msg_data;
                  count_q  <= count_clamp_d;
                  jump_q   <= needs_jump;
                  dest_q   <= jump_dest;
                  busy_q   <= 1'b1;
                  state_q  <= S_MATCH;
               end
            end

            S_MATCH: begin
               tick_q <= 1'b0;
               rw_q   <= RAM_READ;
               if (hit_d) begin
                  done_q    <= 1'b1;
                  deliver_q <= grant_d;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
               end else if (count_q != '0) begin
                  addr_q  <= ADDR_BITS'(SP_WORD_ADDR);
                  state_q <= S_RD_SP;
               end else if (jump_q) begin
                  addr_q  <= ADDR_BITS'(PC_WORD_ADDR);
                  state_q <= S_RD_PC;
               end else begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end

            S_RD_SP: begin
               if (tick_q != ACCESS_LAST) begin
                  tick_q <= ACCESS_LAST;
               end else begin
                  tick_q <= 1'b0;
                  sp_q   <= rd_sp_d;
                  if (collide_d) begin
                     done_q  <= 1'b1;
                     error_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     rw_q    <= RAM_WRITE;
                     din_q   <= sp_word_d;
                     state_q <= S_WR_SP;
                  end
               end
            end

            S_WR_SP: begin
               if (tick_q != ACCESS_LAST) begin
                  tick_q <= ACCESS_LAST;
               end else begin
                  tick_q  <= 1'b0;
                  word_q  <= '0;
                  addr_q  <= sp_q - ADDR_BITS'(1);
                  din_q   <= msg_q[DATA_BITS-1:0];
                  state_q <= S_WR_WORD;
               end
            end

            S_WR_WORD: begin
               if (tick_q != ACCESS_LAST) begin
                  tick_q <= ACCESS_LAST;
               end else begin
                  tick_q <= 1'b0;
                  if (word_d != count_q) begin
                     // Stack grows downward: next word one address lower.
                     word_q <= word_d;
                     addr_q <= addr_q - ADDR_BITS'(1);
                     din_q  <= msg_next_d;
                  end else if (jump_q) begin
                     rw_q    <= RAM_READ;
                     addr_q  <= ADDR_BITS'(PC_WORD_ADDR);
                     state_q <= S_RD_PC;
                  end else begin
                     rw_q    <= RAM_READ;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
            end

            S_RD_PC: begin
               if (tick_q != ACCESS_LAST) begin
                  tick_q <= ACCESS_LAST;
               end else begin
                  tick_q  <= 1'b0;
                  rw_q    <= RAM_WRITE;
                  din_q   <= pc_word_d;
                  state_q <= S_WR_PC;
               end
            end

            S_WR_PC: begin
               if (tick_q != ACCESS_LAST) begin
                  tick_q <= ACCESS_LAST;
               end else begin
                  tick_q  <= 1'b0;
                  rw_q    <= RAM_READ;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end

            default: begin
               rw_q    <= RAM_READ;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign error           = error_q;
   assign deliver_to_core = deliver_q;
   assign mem.mem_rw      = rw_q;
   assign mem.mem_addr    = addr_q;
   assign mem.mem_din     = din_q;

endmodule : message_delivery_multi
`default_nettype wire

// File: tb/tb_message_delivery_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_message_delivery_multi                                     |
// | Purpose  : Self-checking bench for message_delivery_multi with a         |
// |            256-word behavioural process memory.                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_message_delivery_multi;
   import message_delivery_multi_pkg::*;

   localparam int AB = 8;
   localparam int DB = 16;
   localparam int NC = 4;
   localparam int MW = 4;
   localparam int PB = 9;
   localparam int CB = $clog2(MW+1);

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              busy, done, error;
   logic [NC-1:0]     deliver_to_core;
   logic [NC*AB-1:0]  core_process = '0;
   logic [AB-1:0]     target_process = '0;
   logic [MW*DB-1:0]  msg_data = '0;
   logic [CB-1:0]     msg_count = '0;
   logic              needs_jump = 1'b0;
   logic [PB-1:0]     jump_dest = '0;

   message_delivery_multi_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

   message_delivery_multi #(
      .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CORES(NC), .MSG_WORDS_MAX(MW), .PC_BITS(PB)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
      .deliver_to_core(deliver_to_core), .mem(bus.master),
      .core_process(core_process), .target_process(target_process),
      .msg_data(msg_data), .msg_count(msg_count), .needs_jump(needs_jump),
      .jump_dest(jump_dest)
   );

   always #5 clk = ~clk;

   // Behavioural memory: combinational read, write at the clock edge.
   logic [DB-1:0] mem_arr [256];
   logic          clr = 1'b0;
   logic          poke_en = 1'b0;
   logic [AB-1:0] poke_addr = '0;
   logic [DB-1:0] poke_data = '0;
   int            wr_cycles = 0;

   assign bus.mem_dout = mem_arr[bus.mem_addr];

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 256; i++) mem_arr[i] <= '0;
      end else if (poke_en) begin
         mem_arr[poke_addr] <= poke_data;
      end else if (bus.mem_rw == RAM_WRITE) begin
         mem_arr[bus.mem_addr] <= bus.mem_din;
      end
      if (bus.mem_rw == RAM_WRITE) wr_cycles <= wr_cycles + 1;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic clear_mem();
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
   endtask

   task automatic poke(input logic [AB-1:0] a, input logic [DB-1:0] d);
      @(negedge clk); poke_en = 1'b1; poke_addr = a; poke_data = d;
      @(negedge clk); poke_en = 1'b0;
   endtask

   typedef struct {
      logic [NC*AB-1:0] cores;
      logic [AB-1:0]    target;
      logic [DB-1:0]    w0;
      logic [DB-1:0]    w1;
      logic [CB-1:0]    cnt;
      int               eff_cnt;
      logic [MW*DB-1:0] msgs;
      logic             jump;
      logic [PB-1:0]    dest;
      logic [NC-1:0]    exp_grant;
      logic             exp_err;
      int               exp_lat;   // 0: latency not pinned (collision rows)
      logic [DB-1:0]    exp_w0;
      logic [DB-1:0]    exp_w1;
      int               exp_wr;
   } vec_t;

   localparam logic [NC*AB-1:0] NOHIT = {8'd1, 8'd2, 8'd3, 8'd4};

   // Starts a request and waits (bounded) for done; lat counts edges after E0.
   task automatic run_op(input vec_t v, output int lat, output logic err,
                         output logic [NC-1:0] grant);
      @(negedge clk);
      core_process   = v.cores;
      target_process = v.target;
      msg_data       = v.msgs;
      msg_count      = v.cnt;
      needs_jump     = v.jump;
      jump_dest      = v.dest;
      start          = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
      lat = -1; err = 1'bx; grant = 'x;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = n; err = error; grant = deliver_to_core;
            break;
         end
      end
   endtask

   vec_t vecs [9];

   initial begin
      int lat;
      logic err;
      logic [NC-1:0] grant;
      int wr0;

      //          cores               tgt    w0       w1       cnt  eff msgs                                               j  dest    grant    err lat w0       w1       wr
      vecs[0] = '{{8'd7,8'd5,8'd5,8'd3}, 8'd5, 16'h4010, 16'h0000, 3'd2, 2, 64'h0,                                     0, 9'h0,   4'b0010, 0, 1,  16'h4010, 16'h0000, 0};
      vecs[1] = '{NOHIT, 8'h20, 16'h4010, 16'h0000, 3'd3, 3, {16'h0,16'hCCCC,16'hBBBB,16'hAAAA},                    0, 9'h0,   4'b0000, 0, 11, 16'h3D10, 16'h0000, 8};
      vecs[2] = '{NOHIT, 8'h20, 16'h4010, 16'hFE05, 3'd1, 1, {48'h0,16'h1234},                                       1, 9'h123, 4'b0000, 0, 11, 16'h3F10, 16'hFF23, 6};
      vecs[3] = '{NOHIT, 8'h20, 16'h1210, 16'h0000, 3'd3, 3, 64'h1111_2222_3333_4444,                                0, 9'h0,   4'b0000, 1, 0,  16'h1210, 16'h0000, 0};
      vecs[4] = '{NOHIT, 8'h20, 16'h0210, 16'h0000, 3'd3, 3, 64'h1111_2222_3333_4444,                                0, 9'h0,   4'b0000, 1, 0,  16'h0210, 16'h0000, 0};
      vecs[5] = '{NOHIT, 8'h20, 16'h4010, 16'h0000, 3'd0, 0, 64'h0,                                                  0, 9'h0,   4'b0000, 0, 1,  16'h4010, 16'h0000, 0};
      vecs[6] = '{NOHIT, 8'h20, 16'h4010, 16'hA405, 3'd0, 0, 64'h0,                                                  1, 9'h1FF, 4'b0000, 0, 5,  16'h4010, 16'hA5FF, 2};
      vecs[7] = '{NOHIT, 8'h20, 16'h8000, 16'h0000, 3'd7, 4, {16'h4444,16'h3333,16'h2222,16'h1111},                  0, 9'h0,   4'b0000, 0, 13, 16'h7C00, 16'h0000, 10};
      vecs[8] = '{NOHIT, 8'h20, 16'h1410, 16'h0000, 3'd4, 4, {16'h4444,16'h3333,16'h2222,16'h1111},                  0, 9'h0,   4'b0000, 1, 0,  16'h1410, 16'h0000, 0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_deliver", 64'(deliver_to_core), 64'd0);
      chk("rst_mem_rw", 64'(bus.mem_rw), 64'(RAM_READ));
      @(negedge clk); reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         clear_mem();
         poke(8'd0, vecs[i].w0);
         poke(8'd1, vecs[i].w1);
         wr0 = wr_cycles;
         run_op(vecs[i], lat, err, grant);
         if (vecs[i].exp_lat != 0) chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         else                      chk($sformatf("v%0d_completed", i), 64'(lat > 0), 64'd1);
         chk($sformatf("v%0d_error", i), 64'(err), 64'(vecs[i].exp_err));
         chk($sformatf("v%0d_grant", i), 64'(grant), 64'(vecs[i].exp_grant));
         @(posedge clk); #1;
         chk($sformatf("v%0d_busy_after", i), 64'(busy), 64'd0);
         chk($sformatf("v%0d_write_cycles", i), 64'(wr_cycles - wr0), 64'(vecs[i].exp_wr));
         chk($sformatf("v%0d_word0", i), 64'(mem_arr[0]), 64'(vecs[i].exp_w0));
         chk($sformatf("v%0d_word1", i), 64'(mem_arr[1]), 64'(vecs[i].exp_w1));
         if (!vecs[i].exp_err && vecs[i].exp_grant == '0) begin
            for (int k = 0; k < vecs[i].eff_cnt; k++) begin
               logic [AB-1:0] a;
               a = vecs[i].w0[15:8] - 8'(1 + k);
               chk($sformatf("v%0d_msg%0d", i, k), 64'(mem_arr[a]), 64'(vecs[i].msgs[k*DB +: DB]));
            end
         end
      end

      // Boundary just above collision: 0x15-4=0x11 > 0x10
      begin
         vec_t v;
         v = '{NOHIT, 8'h20, 16'h1510, 16'h0000, 3'd4, 4, {16'h4444,16'h3333,16'h2222,16'h1111},
               0, 9'h0, 4'b0000, 0, 13, 16'h1110, 16'h0000, 10};
         clear_mem();
         poke(8'd0, v.w0);
         run_op(v, lat, err, grant);
         chk("edge_latency", 64'(lat), 64'd13);
         chk("edge_error", 64'(err), 64'd0);
         @(posedge clk); #1;
         chk("edge_word0", 64'(mem_arr[0]), 64'h1110);
         chk("edge_msg3", 64'(mem_arr[8'h11]), 64'h4444);
      end

      // Start while busy is ignored: second pulse asks for a zero-word delivery
      begin
         clear_mem();
         poke(8'd0, 16'h4010);
         @(negedge clk);
         core_process = NOHIT; target_process = 8'h20;
         msg_data = {48'h0, 16'h5A5A}; msg_count = 3'd1; needs_jump = 1'b0;
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         repeat (2) @(posedge clk);
         @(negedge clk);
         msg_count = 3'd0; msg_data = '0; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         lat = -1;
         for (int n = 4; n <= 100; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
         end
         chk("busy_start_latency", 64'(lat), 64'd7);
         chk("busy_start_word0", 64'(mem_arr[0]), 64'h3F10);
         chk("busy_start_msg", 64'(mem_arr[8'h3F]), 64'h5A5A);
         wr0 = 0;
         for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (done || busy) wr0++;
         end
         chk("busy_start_no_rerun", 64'(wr0), 64'd0);
      end

      // Reset in the 2nd WR_WORD: E7 begins word 1 (RD_SP 2, WR_SP 2, word0 2)
      begin
         clear_mem();
         poke(8'd0, 16'h4010);
         @(negedge clk);
         core_process = NOHIT; target_process = 8'h20;
         msg_data = {16'h0, 16'hCCCC, 16'hBBBB, 16'hAAAA}; msg_count = 3'd3; needs_jump = 1'b0;
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         repeat (7) @(posedge clk);
         #1;
         chk("rst_mid_in_write", 64'(bus.mem_rw), 64'(RAM_WRITE));
         chk("rst_mid_addr", 64'(bus.mem_addr), 64'h3E);
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
         chk("rst_mid_busy", 64'(busy), 64'd0);
         chk("rst_mid_rw", 64'(bus.mem_rw), 64'(RAM_READ));
         wr0 = wr_cycles;
         repeat (6) @(posedge clk);
         #1;
         chk("rst_mid_no_more_writes", 64'(wr_cycles - wr0), 64'd0);
         chk("rst_mid_word2_unwritten", 64'(mem_arr[8'h3D]), 64'h0);
         chk("rst_mid_word0_written", 64'(mem_arr[8'h3F]), 64'hAAAA);
         chk("rst_mid_done", 64'(done), 64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_message_delivery_multi
`default_nettype wire
